// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: holds up to MAX_ACTIVE lit moles with level-dependent
// lifetimes, scores switch hits, counts misses and sequences IDLE/PLAY/OVER.
module mole_scheduler #(
    parameter int LED_COUNT  = 18,
    parameter int MAX_ACTIVE = 4,
    parameter int LIFE0      = 60_000_000,
    parameter int LIFE1      = 30_000_000,
    parameter int LIFE2      = 15_000_000,
    parameter int LVL1_SCORE = 10,
    parameter int LVL2_SCORE = 25,
    parameter int MAX_MISSES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 led_request,
    input  logic [4:0]           led_index,
    input  logic [LED_COUNT-1:0] sw,
    output logic [LED_COUNT-1:0] led_mask,
    output logic [1:0]           level,
    output logic [9:0]           score,
    output logic [3:0]           misses,
    output logic                 playing,
    output logic                 game_over
);

    localparam int TW = (LIFE0 > 2) ? $clog2(LIFE0) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [MAX_ACTIVE-1:0]  valid_q, valid_d;
    logic [4:0]             idx_q   [MAX_ACTIVE];
    logic [4:0]             idx_d   [MAX_ACTIVE];
    logic [TW-1:0]          timer_q [MAX_ACTIVE];
    logic [TW-1:0]          timer_d [MAX_ACTIVE];
    logic [LED_COUNT-1:0]   sw_q;
    logic [9:0]             score_q, score_d;
    logic [3:0]             misses_q, misses_d;
    logic [1:0]             level_q, level_d;

    logic [LED_COUNT-1:0]   rise;
    logic [LED_COUNT-1:0]   held;
    logic [MAX_ACTIVE-1:0]  hit;
    logic                   stray;
    logic                   dup;
    logic                   free_any;
    int                     free_k;
    int                     n_hit;
    int                     n_to;
    logic [1:0]             lvl_new;

    function automatic logic [LED_COUNT-1:0] onehot(input logic [4:0] idx);
        logic [LED_COUNT-1:0] v;
        v = '0;
        for (int j = 0; j < LED_COUNT; j++) begin
            if (int'(idx) == j) v[j] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [9:0] sat_score(input int v);
        return (v > 1023) ? 10'd1023 : 10'(v);
    endfunction

    function automatic logic [3:0] sat_misses(input int v);
        return (v > MAX_MISSES) ? 4'(MAX_MISSES) : 4'(v);
    endfunction

    function automatic logic [1:0] level_of(input logic [9:0] s);
        if (int'(s) >= LVL2_SCORE) return 2'b10;
        if (int'(s) >= LVL1_SCORE) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [TW-1:0] life_load(input logic [1:0] lv);
        case (lv)
            2'b00:   return TW'(LIFE0 - 1);
            2'b01:   return TW'(LIFE1 - 1);
            default: return TW'(LIFE2 - 1);
        endcase
    endfunction

    // Event decode, all from slot state at the start of the cycle.
    always_comb begin
        rise     = sw & ~sw_q;
        held     = '0;
        hit      = '0;
        free_any = 1'b0;
        free_k   = 0;
        for (int k = 0; k < MAX_ACTIVE; k++) begin
            if (valid_q[k]) begin
                held   = held | onehot(idx_q[k]);
                hit[k] = |(onehot(idx_q[k]) & rise);
            end
        end
        for (int k = MAX_ACTIVE - 1; k >= 0; k--) begin
            if (!valid_q[k]) begin
                free_any = 1'b1;
                free_k   = k;
            end
        end
        stray = |(rise & ~held);
        dup   = |(onehot(led_index) & held);
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        score_d  = score_q;
        misses_d = misses_q;
        level_d  = level_q;
        n_hit    = 0;
        n_to     = 0;
        lvl_new  = 2'b00;

        case (state_q)
            S_PLAY: begin
                for (int k = 0; k < MAX_ACTIVE; k++) begin
                    if (valid_q[k]) begin
                        if (hit[k]) begin
                            valid_d[k] = 1'b0;
                            n_hit      = n_hit + 1;
                        end else if (timer_q[k] == '0) begin
                            valid_d[k] = 1'b0;
                            n_to       = n_to + 1;
                        end else begin
                            timer_d[k] = timer_q[k] - TW'(1);
                        end
                    end
                end
                // Only slots free at cycle start are candidates, so a slot freed above waits a cycle.
                if (led_request && (int'(led_index) < LED_COUNT) && !dup && free_any) begin
                    valid_d[free_k] = 1'b1;
                    idx_d[free_k]   = led_index;
                    timer_d[free_k] = life_load(level_q);
                end
                score_d  = sat_score(int'(score_q) + n_hit);
                misses_d = sat_misses(int'(misses_q) + n_to + int'(stray));
                lvl_new  = level_of(score_d);
                level_d  = (lvl_new > level_q) ? lvl_new : level_q;
                if (int'(misses_d) >= MAX_MISSES) begin
                    state_d = S_OVER;
                    valid_d = '0;
                end
            end
            default: begin
                valid_d = '0;
                if (start) begin
                    state_d  = S_PLAY;
                    score_d  = '0;
                    misses_d = '0;
                    level_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            valid_q  <= '0;
            sw_q     <= '0;
            score_q  <= '0;
            misses_q <= '0;
            level_q  <= '0;
            for (int k = 0; k < MAX_ACTIVE; k++) begin
                idx_q[k]   <= '0;
                timer_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            sw_q     <= sw;
            score_q  <= score_d;
            misses_q <= misses_d;
            level_q  <= level_d;
        end
    end

    always_comb begin
        led_mask = '0;
        for (int k = 0; k < MAX_ACTIVE; k++) begin
            if (valid_q[k]) led_mask = led_mask | onehot(idx_q[k]);
        end
    end

    assign level     = level_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign playing   = (state_q == S_PLAY);
    assign game_over = (state_q == S_OVER);

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Game controller between the LED request generator and the board LEDs/switches of the whack-a-mole design.
- Accepts timed `led_request`/`led_index` pulses and holds up to MAX_ACTIVE lit "moles", each with a level-dependent lifetime.
- Detects switch hits, counts score and misses, and drives the `level` input of the request generator.
- Runs the IDLE/PLAY/OVER game sequence.

Parameters:
- LED_COUNT, 18: number of LEDs/switches; valid indices 0..LED_COUNT-1.
- MAX_ACTIVE, 4: concurrent mole slots.
- LIFE0, 60_000_000: mole lifetime in cycles at level 0.
- LIFE1, 30_000_000: mole lifetime in cycles at level 1.
- LIFE2, 15_000_000: mole lifetime in cycles at level 2.
- LVL1_SCORE, 10: score at which level becomes 1.
- LVL2_SCORE, 25: score at which level becomes 2.
- MAX_MISSES, 8: miss count that ends the game.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle start pulse (debounced upstream).
- led_request  in  1  one-cycle pulse: new mole requested.
- led_index  in  5  LED index, valid with led_request.
- sw  in  LED_COUNT  switch levels, already synchronised to clk.
- led_mask  out  LED_COUNT  bit i high while LED i is an active mole.
- level  out  2  difficulty: 00, 01, 10; to request generator.
- score  out  10  hits, saturating at 1023.
- misses  out  4  misses, saturating at MAX_MISSES.
- playing  out  1  high in PLAY.
- game_over  out  1  high in OVER.

Behaviour:
- Reset: the reset is synchronous and active-low. While rst=0 at a clk edge, every output, the slot table, and the switch history are cleared to 0, and state goes to IDLE.
- Switch history: sw_q <= sw every cycle in all states. A rising edge on bit i is `sw[i] & ~sw_q[i]`.
- FSM states and transitions:
  - IDLE: start -> PLAY.
  - PLAY: misses reaching MAX_MISSES -> OVER.
  - OVER: start -> PLAY.
  - start in PLAY is ignored.
- Entering PLAY, on the start cycle itself:
  - clear score, misses, level, and all slots;
  - next cycle: playing=1, game_over=0.
- IDLE/OVER:
  - led_request and switch edges are ignored;
  - slots stay empty, so led_mask=0;
  - score and misses hold their final values in OVER.
- Slot table: MAX_ACTIVE entries of {valid, idx[4:0], timer}. The timer width covers LIFE0-1.
- Allocation (PLAY, led_request=1):
  - Uses slot state at the start of the cycle.
  - The request is dropped silently if any of these holds: led_index >= LED_COUNT, idx already held by a valid slot, or no free slot.
  - Otherwise the lowest-numbered free slot gets valid=1, idx=led_index, timer=LIFEn-1, where n is the current level.
  - A slot freed in the same cycle is not reused until the next cycle.
- Countdown:
  - Each valid slot not allocated this cycle decrements its timer.
  - When timer==0 and the slot is not hit, it times out: valid<=0, miss +1.
  - An unhit mole is therefore lit for exactly LIFEn cycles.
- Hit: a rising edge on sw[idx] of a valid slot frees that slot and adds score +1. Hit beats timeout on the same cycle.
- Stray press: a rising edge on any bit not held by a valid slot adds miss +1. This counts once per cycle regardless of how many stray bits rose.
- Per-cycle arithmetic:
  - score += number of hit slots, saturating at 1023;
  - misses += timed-out slots + stray flag, saturating at MAX_MISSES.
- Level update: registered from the updated score.
  - level=10 if score>=LVL2_SCORE;
  - else 01 if score>=LVL1_SCORE;
  - else 00.
  - Level never decreases within a game.
  - Slots already lit keep their loaded timer.
- led_mask: decoded from slot registers, OR of one-hot(idx) over valid slots.
  - Request at cycle N -> bit high from N+1.
  - Hit/timeout at cycle N -> bit low from N+1.
- Game over: when updated misses reach MAX_MISSES, the state goes to OVER and all slots are cleared in the same cycle. Remaining events that cycle still count, but results saturate.
- Reset mid-game: next cycle is IDLE with all outputs 0; no residual slots.

Test Plan:
- Use LIFE0=8, LIFE1=4, LIFE2=2, LVL1_SCORE=2, LVL2_SCORE=4, MAX_MISSES=3.
1. Reset then start: after rst=0 for one cycle, all outputs are 0. Start pulse -> playing=1 next cycle, level=00.
2. Timeout: request idx=5 at cycle N -> led_mask[5]=1 for cycles N+1..N+8, low at N+9, misses=1.
3. Hit and level: request idx=3, then sw[3] rises -> led_mask[3]=0 next cycle, score=1. Second hit -> score=2, level=01. The next mole lasts 4 cycles.
4. Slot and duplicate drops:
   - requests for idx 0,1,2,3 fill all slots; a 5th request (idx 4) is dropped, led_mask=0x0000F;
   - a duplicate request for idx 2 while it is active is dropped;
   - a request with idx 20 is dropped.
5. Simultaneous events:
   - sw[7] rises on its final timer cycle -> counts as a hit (score +1), not a miss;
   - two stray bits rising in one cycle -> misses +1 only.
6. Game over: three misses -> game_over=1, playing=0, led_mask=0, and further requests are ignored. Start -> score=0, misses=0, PLAY again.
